// File: rtl/mm_scheduler.sv
// mm_scheduler: accepts MM instructions, issues them to the MM datapath and reports completion
// ports: clk, rstn (async active-low); instr_valid/instr_ready/instr_data instruction handshake;
//        mm_* latched parameters and mm_start_valid pulse to the datapath, mm_done back;
//        cmpl_valid/cmpl_ready/cmpl_status completion record with busy_cycles of the last instruction
module mm_scheduler #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1048576
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [79:0]      instr_data,
  output logic [12:0]      mm_weight_start_addr,
  output logic [10:0]      mm_input_start_addr,
  output logic [10:0]      mm_output_start_addr,
  output logic [8:0]       mm_bias_start_addr,
  output logic [7:0]       mm_ci,
  output logic [7:0]       mm_co,
  output logic [15:0]      mm_n,
  output logic             mm_r,
  output logic             mm_a,
  output logic             mm_b,
  output logic             mm_start_valid,
  input  logic             mm_done,
  output logic             cmpl_valid,
  input  logic             cmpl_ready,
  output logic [1:0]       cmpl_status,
  output logic [CNT_W-1:0] busy_cycles
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, CMPL} state_t;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  state_t state, state_nx;
  logic alive, xfer, bad, tout, unused_rsvd;
  logic [CNT_W-1:0] cnt_inc;
  // alive keeps instr_ready low while rstn is held, without touching the state encoding
  assign instr_ready = alive && state == IDLE;
  assign cmpl_valid = state == CMPL;
  assign xfer = instr_valid && instr_ready;
  assign bad = instr_data[51:44] == '0 || instr_data[59:52] == '0 || instr_data[75:60] == '0;
  assign cnt_inc = &busy_cycles ? busy_cycles : busy_cycles + 1'b1;
  // timeout fires on the BUSY cycle whose count lands on TIMEOUT-1
  assign tout = cnt_inc == TO_LAST;
  assign unused_rsvd = instr_data[79];
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (xfer ? (bad ? CMPL : ISSUE) : IDLE) :
               state == ISSUE ? BUSY :
               state == BUSY  ? ((mm_done || tout) ? CMPL : BUSY) :
                                (cmpl_ready ? IDLE : CMPL);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      alive <= 1'b0;
      mm_start_valid <= 1'b0;
      cmpl_status <= 2'b00;
      busy_cycles <= '0;
      mm_weight_start_addr <= '0;
      mm_input_start_addr <= '0;
      mm_output_start_addr <= '0;
      mm_bias_start_addr <= '0;
      mm_ci <= '0;
      mm_co <= '0;
      mm_n <= '0;
      mm_r <= 1'b0;
      mm_a <= 1'b0;
      mm_b <= 1'b0;
    end else begin
      alive <= 1'b1;
      mm_start_valid <= xfer && !bad;
      if (xfer) begin
        {mm_b, mm_a, mm_r, mm_n, mm_co, mm_ci, mm_bias_start_addr, mm_output_start_addr,
         mm_input_start_addr, mm_weight_start_addr} <= instr_data[78:0];
        busy_cycles <= '0;
        cmpl_status <= bad ? 2'b01 : 2'b00;
      end
      if (state == BUSY) begin
        busy_cycles <= cnt_inc;
        if (mm_done || tout) cmpl_status <= mm_done ? 2'b00 : 2'b10;
      end
    end
endmodule

// File: tb/tb_mm_scheduler.sv
// tb_mm_scheduler: directed self-checking bench for mm_scheduler (default and TIMEOUT=16 instances)
module tb_mm_scheduler;
  logic clk = 1'b0, rstn = 1'b0, instr_valid = 1'b0, mm_done = 1'b0, cmpl_ready = 1'b0, sel = 1'b0;
  logic [79:0] instr_data = '0;
  wire [78:0] p0, p1;
  logic ir0, ir1, sv0, sv1, cv0, cv1;
  logic [1:0] st0, st1;
  logic [31:0] bc0, bc1;
  logic iv0, iv1, ir, sv, cv;
  logic [1:0] st;
  logic [31:0] bc;
  logic [78:0] p;
  int checks = 0, errors = 0, starts = 0;
  always #5 clk = ~clk;
  assign iv0 = instr_valid && !sel;
  assign iv1 = instr_valid && sel;
  assign ir = sel ? ir1 : ir0;
  assign sv = sel ? sv1 : sv0;
  assign cv = sel ? cv1 : cv0;
  assign st = sel ? st1 : st0;
  assign bc = sel ? bc1 : bc0;
  assign p = sel ? p1 : p0;
  mm_scheduler u_dut0 (
    .clk(clk), .rstn(rstn), .instr_valid(iv0), .instr_ready(ir0), .instr_data(instr_data),
    .mm_weight_start_addr(p0[12:0]), .mm_input_start_addr(p0[23:13]), .mm_output_start_addr(p0[34:24]),
    .mm_bias_start_addr(p0[43:35]), .mm_ci(p0[51:44]), .mm_co(p0[59:52]), .mm_n(p0[75:60]),
    .mm_r(p0[76]), .mm_a(p0[77]), .mm_b(p0[78]), .mm_start_valid(sv0), .mm_done(mm_done),
    .cmpl_valid(cv0), .cmpl_ready(cmpl_ready), .cmpl_status(st0), .busy_cycles(bc0));
  mm_scheduler #(.TIMEOUT(16)) u_dut1 (
    .clk(clk), .rstn(rstn), .instr_valid(iv1), .instr_ready(ir1), .instr_data(instr_data),
    .mm_weight_start_addr(p1[12:0]), .mm_input_start_addr(p1[23:13]), .mm_output_start_addr(p1[34:24]),
    .mm_bias_start_addr(p1[43:35]), .mm_ci(p1[51:44]), .mm_co(p1[59:52]), .mm_n(p1[75:60]),
    .mm_r(p1[76]), .mm_a(p1[77]), .mm_b(p1[78]), .mm_start_valid(sv1), .mm_done(mm_done),
    .cmpl_valid(cv1), .cmpl_ready(cmpl_ready), .cmpl_status(st1), .busy_cycles(bc1));
  always @(negedge clk) if (sv === 1'b1) starts++;
  function automatic logic [79:0] mk(input logic [12:0] w, input logic [10:0] i, input logic [10:0] o,
                                     input logic [8:0] bs, input logic [7:0] ci, input logic [7:0] co,
                                     input logic [15:0] n, input logic r, input logic a, input logic b);
    return {1'b0, b, a, r, n, co, ci, bs, o, i, w};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ack;
    cmpl_ready = 1'b1;
    tick();
    cmpl_ready = 1'b0;
  endtask
  task automatic test_reset;
    #3;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({ir, sv, cv, st, bc, p} !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got ir=%b sv=%b cv=%b st=%b bc=%0d p=%h, want all 0", s, ir, sv, cv, st, bc, p);
      end
    end
    sel = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if (ir !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", ir); end
  endtask
  task automatic test_legal;
    logic [79:0] d;
    int s0;
    sel = 1'b0;
    d = mk(13'h1abc, 11'h5a5, 11'h2c3, 9'h1f0, 8'd2, 8'd3, 16'd4, 1'b1, 1'b0, 1'b1);
    d[79] = 1'b1;
    s0 = starts;
    instr_valid = 1'b1;
    instr_data = d;
    tick();
    instr_valid = 1'b0;
    checks++;
    if (sv !== 1'b1) begin errors++; $display("FAIL legal_start: got %b want 1", sv); end
    checks++;
    if (p !== d[78:0]) begin errors++; $display("FAIL legal_params: got %h want %h", p, d[78:0]); end
    repeat (29) tick();
    checks++;
    if (cv !== 1'b0) begin errors++; $display("FAIL legal_still_busy: got cv=%b want 0", cv); end
    tick();
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    checks++;
    if ({cv, st} !== 3'b100) begin errors++; $display("FAIL legal_cmpl: got cv=%b st=%b want 1/00", cv, st); end
    checks++;
    if (bc !== 32'd30) begin errors++; $display("FAIL legal_busy_cycles: got %0d want 30", bc); end
    checks++;
    if (starts - s0 !== 1) begin errors++; $display("FAIL legal_one_pulse: got %0d want 1", starts - s0); end
    checks++;
    if (p !== d[78:0]) begin errors++; $display("FAIL legal_params_hold: got %h want %h", p, d[78:0]); end
    ack();
    checks++;
    if ({cv, ir} !== 2'b01) begin errors++; $display("FAIL legal_back_idle: got cv=%b ir=%b want 0/1", cv, ir); end
  endtask
  task automatic test_bad_param;
    logic [79:0] d;
    int s0;
    sel = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = mk(13'h0042, 11'h011, 11'h022, 9'h033, k == 0 ? 8'd0 : 8'd5, k == 1 ? 8'd0 : 8'd6,
             k == 2 ? 16'd0 : 16'd7, 1'b0, 1'b1, 1'b0);
      s0 = starts;
      instr_valid = 1'b1;
      instr_data = d;
      tick();
      instr_valid = 1'b0;
      checks++;
      if ({cv, st, sv} !== 4'b1010) begin
        errors++;
        $display("FAIL bad_param_cmpl%0d: got cv=%b st=%b sv=%b want 1/01/0", k, cv, st, sv);
      end
      checks++;
      if (bc !== 32'd0) begin errors++; $display("FAIL bad_param_busy%0d: got %0d want 0", k, bc); end
      checks++;
      if (p !== d[78:0]) begin errors++; $display("FAIL bad_param_params%0d: got %h want %h", k, p, d[78:0]); end
      repeat (3) tick();
      checks++;
      if (starts !== s0 || cv !== 1'b1) begin
        errors++;
        $display("FAIL bad_param_nopulse%0d: got pulses=%0d cv=%b want 0/1", k, starts - s0, cv);
      end
      ack();
    end
  endtask
  task automatic test_timeout;
    sel = 1'b1;
    instr_valid = 1'b1;
    instr_data = mk(13'h0001, 11'h002, 11'h003, 9'h004, 8'd1, 8'd1, 16'd1, 1'b0, 1'b0, 1'b0);
    tick();
    instr_valid = 1'b0;
    repeat (15) tick();
    checks++;
    if (cv !== 1'b0 || bc !== 32'd14) begin
      errors++;
      $display("FAIL timeout_before: got cv=%b bc=%0d want 0/14", cv, bc);
    end
    tick();
    checks++;
    if ({cv, st} !== 3'b110 || bc !== 32'd15) begin
      errors++;
      $display("FAIL timeout_cmpl: got cv=%b st=%b bc=%0d want 1/10/15", cv, st, bc);
    end
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    tick();
    checks++;
    if ({cv, st, sv} !== 4'b1100 || bc !== 32'd15) begin
      errors++;
      $display("FAIL timeout_done_ignored: got cv=%b st=%b sv=%b bc=%0d want 1/10/0/15", cv, st, sv, bc);
    end
    ack();
  endtask
  task automatic test_coincident;
    sel = 1'b1;
    instr_valid = 1'b1;
    instr_data = mk(13'h0100, 11'h020, 11'h030, 9'h040, 8'd9, 8'd8, 16'd7, 1'b1, 1'b1, 1'b1);
    tick();
    instr_valid = 1'b0;
    repeat (15) tick();
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    checks++;
    if ({cv, st} !== 3'b100 || bc !== 32'd15) begin
      errors++;
      $display("FAIL coincident_done: got cv=%b st=%b bc=%0d want 1/00/15", cv, st, bc);
    end
    ack();
  endtask
  task automatic test_back_to_back;
    logic [79:0] d1, d2;
    int s0;
    sel = 1'b0;
    d1 = mk(13'h0aaa, 11'h155, 11'h0ff, 9'h0aa, 8'd1, 8'd2, 16'd3, 1'b0, 1'b1, 1'b1);
    d2 = mk(13'h1555, 11'h2aa, 11'h700, 9'h155, 8'd4, 8'd5, 16'd6, 1'b1, 1'b0, 1'b0);
    instr_valid = 1'b1;
    instr_data = d1;
    tick();
    instr_data = d2;
    repeat (3) tick();
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    checks++;
    if ({cv, st} !== 3'b100 || bc !== 32'd3) begin
      errors++;
      $display("FAIL b2b_first_cmpl: got cv=%b st=%b bc=%0d want 1/00/3", cv, st, bc);
    end
    s0 = starts;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({cv, ir} !== 2'b10) begin errors++; $display("FAIL b2b_hold%0d: got cv=%b ir=%b want 1/0", k, cv, ir); end
    end
    checks++;
    if (starts !== s0 || p !== d1[78:0]) begin
      errors++;
      $display("FAIL b2b_no_second: got pulses=%0d p=%h want 0/%h", starts - s0, p, d1[78:0]);
    end
    ack();
    checks++;
    if ({cv, ir} !== 2'b01) begin errors++; $display("FAIL b2b_bubble: got cv=%b ir=%b want 0/1", cv, ir); end
    tick();
    instr_valid = 1'b0;
    checks++;
    if (sv !== 1'b1 || p !== d2[78:0]) begin
      errors++;
      $display("FAIL b2b_accept: got sv=%b p=%h want 1/%h", sv, p, d2[78:0]);
    end
    repeat (2) tick();
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    checks++;
    if ({cv, st} !== 3'b100 || bc !== 32'd2) begin
      errors++;
      $display("FAIL b2b_second_cmpl: got cv=%b st=%b bc=%0d want 1/00/2", cv, st, bc);
    end
    ack();
  endtask
  task automatic test_reset_busy;
    logic [79:0] d;
    sel = 1'b0;
    instr_valid = 1'b1;
    instr_data = mk(13'h0123, 11'h045, 11'h067, 9'h089, 8'd3, 8'd3, 16'd3, 1'b1, 1'b1, 1'b1);
    tick();
    instr_valid = 1'b0;
    repeat (5) tick();
    rstn = 1'b0;
    #1;
    checks++;
    if ({ir, sv, cv, st, bc, p} !== '0) begin
      errors++;
      $display("FAIL reset_busy_outputs: got ir=%b sv=%b cv=%b st=%b bc=%0d p=%h want all 0", ir, sv, cv, st, bc, p);
    end
    tick();
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if ({cv, ir} !== 2'b01) begin errors++; $display("FAIL reset_busy_no_stale: got cv=%b ir=%b want 0/1", cv, ir); end
    d = mk(13'h1fff, 11'h7ff, 11'h001, 9'h1ff, 8'hff, 8'hff, 16'hffff, 1'b0, 1'b0, 1'b1);
    instr_valid = 1'b1;
    instr_data = d;
    tick();
    instr_valid = 1'b0;
    checks++;
    if (sv !== 1'b1 || p !== d[78:0]) begin
      errors++;
      $display("FAIL reset_busy_new_start: got sv=%b p=%h want 1/%h", sv, p, d[78:0]);
    end
    repeat (4) tick();
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    checks++;
    if ({cv, st} !== 3'b100 || bc !== 32'd4) begin
      errors++;
      $display("FAIL reset_busy_new_cmpl: got cv=%b st=%b bc=%0d want 1/00/4", cv, st, bc);
    end
    ack();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_legal();
    test_bad_param();
    test_timeout();
    test_coincident();
    test_back_to_back();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
